// File: rtl/exception_status_queue.sv
// rtl/exception_status_queue.sv - dual-source exception status FIFO retiring into rstatus
// Optional feature macro EXC_CAUSE_MASK_EN adds a sticky per-cause mask (cause_mask / cause_clr).
module exception_status_queue #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 8,
   parameter int RSTATUS_ADDR = 30
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [31:0]               instruction,
   input  logic                      ovf,
   input  logic [DATA_W-1:0]         setXVal,
   input  logic                      md_valid,
   input  logic                      md_is_div,
   input  logic                      flush,
   output logic                      rs_valid,
   output logic [DATA_W-1:0]         rs_data,
   output logic [4:0]                rs_addr,
   input  logic                      rs_ready,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic [CNT_W-1:0]          drop_cnt
`ifdef EXC_CAUSE_MASK_EN
   ,
   output logic [5:0]                cause_mask,
   input  logic                      cause_clr
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = CW + 1;
   localparam int DW = CNT_W + 2;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;

   logic [4:0] opcode, aluop;
   logic       is_add, is_sub, is_addi, is_setx;
   logic       unused_instr_bits;

   assign opcode  = instruction[31:27];
   assign aluop   = instruction[6:2];
   assign is_add  = (opcode == 5'b00000) && (aluop == 5'b00000);
   assign is_sub  = (opcode == 5'b00000) && (aluop == 5'b00001);
   assign is_addi = (opcode == 5'b00101);
   assign is_setx = (opcode == 5'b10101);
   assign unused_instr_bits = ^{instruction[26:7], instruction[1:0]};

   logic              alu_ev;
   logic [DATA_W-1:0] alu_code;
   logic [DATA_W-1:0] md_code;

   always_comb begin
      alu_ev   = 1'b0;
      alu_code = '0;
      if (in_valid) begin
         if (is_setx) begin
            alu_ev   = 1'b1;
            alu_code = setXVal;
         end else if (ovf && is_add) begin
            alu_ev   = 1'b1;
            alu_code = DATA_W'(1);
         end else if (ovf && is_addi) begin
            alu_ev   = 1'b1;
            alu_code = DATA_W'(2);
         end else if (ovf && is_sub) begin
            alu_ev   = 1'b1;
            alu_code = DATA_W'(3);
         end
      end
   end

   assign md_code = md_is_div ? DATA_W'(5) : DATA_W'(4);

   // MD is the older event, so it claims the first free slot; ALU only gets a leftover slot.
   logic          pop;
   logic [FW-1:0] free;
   logic          md_acc, alu_acc;
   logic [1:0]    n_push, n_drop;

   assign pop     = rs_valid & rs_ready;
   assign free    = FW'(DEPTH) - FW'(count) + FW'(pop);
   assign md_acc  = md_valid && (free != '0);
   assign alu_acc = alu_ev && (free > FW'(md_acc));
   assign n_push  = 2'(md_acc) + 2'(alu_acc);
   assign n_drop  = 2'(md_valid & ~md_acc) + 2'(alu_ev & ~alu_acc);

   logic [DATA_W-1:0] first_data;
   logic [PW-1:0]     wr_nxt1, rd_nxt;
   logic [CW-1:0]     remain;
   logic [DATA_W-1:0] head_next;

   assign first_data = md_acc ? md_code : alu_code;
   assign wr_nxt1    = wr_ptr + PW'(1);
   assign rd_nxt     = rd_ptr + PW'(pop);
   assign remain     = count - CW'(pop);

   // rs_data is a register, so the next head is chosen here: a survivor, else the first push.
   always_comb begin
      head_next = '0;
      if (remain != '0)
         head_next = mem[rd_nxt];
      else if (n_push != 2'd0)
         head_next = first_data;
   end

   logic [DW-1:0]    drop_sum;
   logic [CNT_W-1:0] drop_next;

   assign drop_sum  = {2'b00, drop_cnt} + DW'(n_drop);
   assign drop_next = (drop_sum[DW-1:CNT_W] != 2'b00) ? '1 : drop_sum[CNT_W-1:0];

   always_ff @(posedge clock) begin
      if (reset && !flush) begin
         if (n_push != 2'd0)
            mem[wr_ptr] <= first_data;
         if (n_push == 2'd2)
            mem[wr_nxt1] <= alu_code;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
         rs_data  <= '0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         rs_data  <= '0;
      end else begin
         rd_ptr   <= rd_nxt;
         wr_ptr   <= wr_ptr + PW'(n_push);
         count    <= remain + CW'(n_push);
         drop_cnt <= drop_next;
         rs_data  <= head_next;
      end
   end

   assign rs_valid = (count != '0);
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign rs_addr  = 5'(RSTATUS_ADDR);

`ifdef EXC_CAUSE_MASK_EN
   logic [5:0] set_bits;

   assign set_bits = {alu_acc & is_setx,
                      md_acc & md_is_div,
                      md_acc & ~md_is_div,
                      alu_acc & is_sub,
                      alu_acc & is_addi,
                      alu_acc & is_add};

   // Discarded flush-cycle pushes never set a cause; set beats a same-cycle clear.
   always_ff @(posedge clock) begin
      if (!reset)
         cause_mask <= '0;
      else
         cause_mask <= (cause_clr ? 6'b0 : cause_mask) | (flush ? 6'b0 : set_bits);
   end
`endif

endmodule
